dmem_lsu: RTL

- Load/store unit: the initiator side of the word-only data memory interface (readEn/writeEn/address/datain/dataout).
- Accepts byte, halfword and word load/store requests from the CPU execute stage over a valid/ready handshake.
- Performs alignment checks, big-endian lane extraction with sign/zero extension, and read-modify-write for sub-word stores. The memory itself only writes whole aligned words.
- Sits between the execute stage and the data memory.

---
 rtl/dmem_lsu_if.sv | 39 +++
 rtl/dmem_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus word-only data-memory bus of the load/store unit.
// slave = the LSU's view, master = execute stage and memory side.
interface dmem_lsu_if #(
    parameter int N = 32
);
    // execute-stage request / response
    logic         req_valid;
    logic         req_ready;
    logic         req_load;
    logic         req_store;
    logic [1:0]   req_size;
    logic         req_signed;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         resp_valid;
    logic [N-1:0] resp_rdata;
    logic         resp_err;

    // data memory, whole aligned words only
    logic         mem_readEn;
    logic         mem_writeEn;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_datain;
    logic [N-1:0] mem_dataout;

    modport slave (
        input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
        input  mem_dataout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_readEn, mem_writeEn, mem_address, mem_datain
    );

    modport master (
        output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata,
        output mem_dataout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_readEn, mem_writeEn, mem_address, mem_datain
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: big-endian byte/half/word access to a word-only memory with RMW for sub-word stores.
// Optional macro DMEM_LSU_MISALIGN_TRAP_EN: misaligned half/word requests error out instead of aligning down.
module dmem_lsu #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_lsu_if.slave  bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t       state_reg;
    state_t       state_next;

    logic         load_reg;
    logic         signed_reg;
    logic         err_reg;
    logic [1:0]   size_reg;
    logic [N-1:0] addr_reg;
    logic [N-1:0] wdata_reg;
    logic [N-1:0] wbuf_reg;
    logic [N-1:0] rdata_reg;

    logic         accept;
    logic         req_err;
    logic [N-1:0] req_addr_eff;
    logic [N-1:0] mem_aligned_addr;

    logic [7:0]   lane_byte [4];
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;
    logic [N-1:0] load_ext;
    logic [N-1:0] merged_word;

    // ------------------------------------------------------------------
    // Request decode: error classification and effective address
    // ------------------------------------------------------------------
    always_comb begin
        req_addr_eff = bus.req_addr;
        req_err      = (bus.req_load == bus.req_store) || (bus.req_size == SZ_BAD);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
            (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`else
        // misaligned accesses are quietly pulled down to their natural boundary
        if (bus.req_size == SZ_HALF) begin
            req_addr_eff[0] = 1'b0;
        end else if (bus.req_size == SZ_WORD) begin
            req_addr_eff[1:0] = 2'b00;
        end
`endif
    end

    assign mem_aligned_addr = {addr_reg[N-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Lane extraction and sub-word merge; lane 0 is the most significant byte
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] half_src;
            logic       hit_byte;
            logic       hit_half;

            if (gi % 2 == 0) begin : g_hi
                assign half_src = wdata_reg[15:8];
            end else begin : g_lo
                assign half_src = wdata_reg[7:0];
            end

            assign lane_byte[gi] = bus.mem_dataout[N-1-8*gi -: 8];
            assign hit_byte      = (size_reg == SZ_BYTE) && (addr_reg[1:0] == 2'(gi));
            assign hit_half      = (size_reg == SZ_HALF) && (addr_reg[1] == 1'(gi / 2));
            assign merged_word[N-1-8*gi -: 8] = hit_byte ? wdata_reg[7:0] :
                                                hit_half ? half_src       :
                                                           lane_byte[gi];
        end
    endgenerate

    assign sel_byte = lane_byte[addr_reg[1:0]];
    assign sel_half = addr_reg[1] ? bus.mem_dataout[15:0] : bus.mem_dataout[N-1:16];

    always_comb begin
        case (size_reg)
            SZ_BYTE: load_ext = {{(N-8){signed_reg & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_ext = {{(N-16){signed_reg & sel_half[15]}}, sel_half};
            default: load_ext = bus.mem_dataout;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        accept          = 1'b0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_err    = 1'b0;
        bus.mem_readEn  = 1'b0;
        bus.mem_writeEn = 1'b0;
        bus.mem_address = '0;
        bus.mem_datain  = '0;

        case (state_reg)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_next = RESP;
                    end else if (bus.req_load) begin
                        state_next = RD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_next = WR;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            RD: begin
                bus.mem_readEn  = 1'b1;
                bus.mem_address = mem_aligned_addr;
                state_next      = RESP;
            end
            RMW_RD: begin
                bus.mem_readEn  = 1'b1;
                bus.mem_address = mem_aligned_addr;
                state_next      = WR;
            end
            WR: begin
                bus.mem_writeEn = 1'b1;
                bus.mem_address = mem_aligned_addr;
                bus.mem_datain  = (size_reg == SZ_WORD) ? wdata_reg : wbuf_reg;
                state_next      = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_reg;
                bus.resp_rdata = (load_reg && !err_reg) ? rdata_reg : '0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_reg   <= 1'b0;
            signed_reg <= 1'b0;
            err_reg    <= 1'b0;
            size_reg   <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wbuf_reg   <= '0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        load_reg   <= bus.req_load;
                        signed_reg <= bus.req_signed;
                        err_reg    <= req_err;
                        size_reg   <= bus.req_size;
                        addr_reg   <= req_addr_eff;
                        wdata_reg  <= bus.req_wdata;
                        wbuf_reg   <= '0;
                        rdata_reg  <= '0;
                    end
                end
                RD: begin
                    rdata_reg <= load_ext;
                end
                RMW_RD: begin
                    wbuf_reg <= merged_word;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
